// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: RMII 100 Mb/s transmit framer. Takes MAC frame bytes (DA..payload)
// and emits preamble/SFD, payload, optional zero padding, FCS, then holds the inter-packet gap.
// Ports: clk/reset_n (sync, active-low); s_data/s_valid/s_last/s_ready byte stream in;
// txd/tx_en registered RMII pins; busy, underrun and frame_done status pulses.
// Latency: accept in IDLE at T -> first preamble dibit at T+1, SFD at T+32, data at T+33.
// Backpressure: s_ready is combinational from state/dibit counter only; one byte per 4 clocks.
// Optional feature: define RMII_TX_PAD_EN to pad frames shorter than MIN_BYTES with 0x00.

// crc_gen: right-shifting CRC-32 (0xEDB88320), two input bits per clock, bit 0 first.
// crc_out is the inverted CRC of everything fed so far including the current data_in.
module crc_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        crc_en,
  input  logic [1:0]  data_in,
  output logic [31:0] crc_out
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_en) begin
      for (int i = 0; i < 2; i++) begin
        crc_d = (crc_d >> 1) ^ (((crc_d[0] ^ data_in[i]) != 1'b0) ? 32'hEDB88320 : 32'h0);
      end
    end
  end

  assign crc_out = ~crc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) crc_q <= 32'hFFFFFFFF;
    else          crc_q <= crc_d;
  end
endmodule

module rmii_tx_framer #(
  parameter int MIN_BYTES  = 60,
  parameter int IPG_CYCLES = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [1:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);
  localparam int IW = $clog2(IPG_CYCLES + 1);
`ifdef RMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, DRAIN, IPG} state_t;

  // All *_q registers describe what is on the pins this cycle; *_d is what loads next.
  state_t        state_q, state_d;
  logic [4:0]    dib_q, dib_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [IW-1:0] ipg_q, ipg_d;
  logic [31:0]   fcs_q;
  logic [1:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          underrun_q, underrun_d;
  logic          frame_done_q, frame_done_d;

  logic [4:0]    dib_inc;
  logic [10:0]   cnt_inc;
  logic          pad_needed;
  logic          crc_en, crc_clr, crc_rst_n;
  logic [31:0]   crc_out;

  function automatic logic [1:0] dibit8(input logic [7:0] b, input logic [1:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] dibit32(input logic [31:0] w, input logic [3:0] i);
    return w[{i, 1'b0} +: 2];
  endfunction

  assign dib_inc    = dib_q + 5'd1;
  assign cnt_inc    = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign pad_needed = PAD_EN && (cnt_q < 11'(MIN_BYTES));

  always_comb begin
    s_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE:    s_ready = 1'b1;
        DATA:    s_ready = (dib_q == 5'd3) && !last_q;
        DRAIN:   s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    dib_d        = dib_q;
    byte_d       = byte_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ipg_d        = ipg_q;
    txd_d        = 2'b00;
    tx_en_d      = 1'b0;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          byte_d  = s_data;
          last_d  = s_last;
          state_d = PRE;
          dib_d   = 5'd0;
          txd_d   = 2'b01;
          tx_en_d = 1'b1;
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (dib_q == 5'd31) begin
          state_d = DATA;
          dib_d   = 5'd0;
          cnt_d   = 11'd1;
          txd_d   = dibit8(byte_q, 2'd0);
        end else begin
          dib_d = dib_inc;
          txd_d = (dib_q == 5'd30) ? 2'b11 : 2'b01;
        end
      end
      DATA, PAD: begin
        tx_en_d = 1'b1;
        if (dib_q != 5'd3) begin
          dib_d = dib_inc;
          txd_d = dibit8(byte_q, dib_inc[1:0]);
        end else if (state_q == DATA && !last_q) begin
          if (s_valid) begin
            byte_d = s_data;
            last_d = s_last;
            dib_d  = 5'd0;
            cnt_d  = cnt_inc;
            txd_d  = dibit8(s_data, 2'd0);
          end else begin
            // Ready is only offered before s_last is seen, so an underrun
            // always leaves the rest of the frame to be discarded.
            tx_en_d    = 1'b0;
            underrun_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (pad_needed) begin
          state_d = PAD;
          byte_d  = 8'h00;
          dib_d   = 5'd0;
          cnt_d   = cnt_inc;
        end else begin
          state_d = FCS;
          dib_d   = 5'd0;
          txd_d   = dibit32(fcs_q, 4'd0);
        end
      end
      FCS: begin
        if (dib_q == 5'd15) begin
          state_d = IPG;
          ipg_d   = IW'(IPG_CYCLES - 1);
        end else begin
          tx_en_d      = 1'b1;
          dib_d        = dib_inc;
          txd_d        = dibit32(fcs_q, dib_inc[3:0]);
          frame_done_d = (dib_q == 5'd14);
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          state_d = IPG;
          ipg_d   = IW'(IPG_CYCLES - 1);
        end
      end
      IPG: begin
        // The IDLE cycle that accepts the next byte is itself the last gap
        // cycle, so the gap state lasts one clock less than IPG_CYCLES.
        if (ipg_q <= IW'(1)) state_d = IDLE;
        else                 ipg_d   = ipg_q - IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // CRC sees exactly the dibits entering txd during DATA/PAD; it is held in
  // its initial value while preamble dibits are being loaded.
  assign crc_en    = (state_d == DATA) || (state_d == PAD);
  assign crc_clr   = (state_d == PRE);
  assign crc_rst_n = reset_n & ~crc_clr;

  crc_gen u_crc (
    .clk     (clk),
    .reset_n (crc_rst_n),
    .crc_en  (crc_en),
    .data_in (txd_d),
    .crc_out (crc_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dib_q        <= 5'd0;
      byte_q       <= 8'h00;
      last_q       <= 1'b0;
      cnt_q        <= 11'd0;
      ipg_q        <= '0;
      fcs_q        <= 32'h0;
      txd_q        <= 2'b00;
      tx_en_q      <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dib_q        <= dib_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ipg_q        <= ipg_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
      // Captured on every fed dibit; the value left after the final
      // DATA/PAD dibit is the frame's FCS.
      if (crc_en) fcs_q <= crc_out;
    end
  end

  assign txd        = txd_q;
  assign tx_en      = tx_en_q;
  assign busy       = (state_q != IDLE);
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;
endmodule
